// File: rtl/switch_array_input_pkg.sv
// Shared types and constants for the switch input path.
package switch_array_input_pkg;

  // Change-event handshake state: nothing pending, or an event waiting to be taken.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ev_state_e;

  // 1 ms of stability at a 50 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/switch_array_input_if.sv
// Valid/ready change-event port between the switch block and its consumer.
interface switch_array_input_if #(
  parameter int WIDTH = 8
);
  logic             event_valid;
  logic             event_ready;
  logic [WIDTH-1:0] event_data;
  logic [WIDTH-1:0] event_mask;
  logic             event_overrun;

  modport master (
    output event_valid, event_data, event_mask, event_overrun,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_data, event_mask, event_overrun,
    output event_ready
  );
endinterface

// File: rtl/switch_array_input_debounce_bit.sv
// One switch pin: 2-flop synchronizer, optional inversion, stability counter,
// debounced level and single-cycle rise/fall pulses.
module switch_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic             r_level, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in;

  // Inversion sits after the synchronizer so the sync flops see the raw pin.
  assign w_in = r_sync2 ^ ACTIVE_LOW;

  // Bring the asynchronous pin into the CLK domain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row;
  // any return to the current level restarts the count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_in == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_in;
        r_cnt   <= '0;
        r_rise  <= w_in;
        r_fall  <= ~w_in;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/switch_array_input.sv
// Board switch bank: per-bit debounce lanes plus a change-event FSM that merges
// accepted edges into a single pending valid/ready event.
module switch_array_input
  import switch_array_input_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [WIDTH-1:0]     sw_in,
  output logic [WIDTH-1:0]     sw_level,
  output logic [WIDTH-1:0]     sw_rise,
  output logic [WIDTH-1:0]     sw_fall,
  switch_array_input_if.master ev
);

  wire  [WIDTH-1:0] w_level;
  wire  [WIDTH-1:0] w_rise;
  wire  [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_chg;

  ev_state_e        r_state, w_state_nx;
  logic [WIDTH-1:0] r_data, w_data_nx;
  logic [WIDTH-1:0] r_mask, w_mask_nx;
  logic             r_ovr, w_ovr_nx;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .i_pin   (sw_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  assign sw_level = w_level;
  assign sw_rise  = w_rise;
  assign sw_fall  = w_fall;

  // Pulses are registered in the lanes, so the FSM sees them one edge after they fire.
  assign w_chg = w_rise | w_fall;

  // Next-state: open, merge into, hand off, or restart the pending event.
  // A change on the handshake edge starts a fresh event so nothing is dropped.
  always_comb begin
    w_state_nx = r_state;
    w_data_nx  = r_data;
    w_mask_nx  = r_mask;
    w_ovr_nx   = r_ovr;
    case (r_state)
      ST_IDLE: begin
        if (w_chg != '0) begin
          w_state_nx = ST_PEND;
          w_data_nx  = w_level;
          w_mask_nx  = w_chg;
          w_ovr_nx   = 1'b0;
        end
      end
      ST_PEND: begin
        if (ev.event_ready) begin
          if (w_chg != '0) begin
            w_data_nx = w_level;
            w_mask_nx = w_chg;
            w_ovr_nx  = 1'b0;
          end else begin
            w_state_nx = ST_IDLE;
            w_mask_nx  = '0;
            w_ovr_nx   = 1'b0;
          end
        end else if (w_chg != '0) begin
          w_data_nx = w_level;
          w_mask_nx = r_mask | w_chg;
          w_ovr_nx  = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Event state and payload registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_mask  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_data  <= w_data_nx;
      r_mask  <= w_mask_nx;
      r_ovr   <= w_ovr_nx;
    end
  end

  assign ev.event_valid   = (r_state == ST_PEND);
  assign ev.event_data    = r_data;
  assign ev.event_mask    = r_mask;
  assign ev.event_overrun = r_ovr;

endmodule

// File: tb/tb_switch_array_input.sv
// Bench for switch_array_input: an active-high and an active-low instance,
// a window-based reference model, pulse/transfer scoreboards and directed checks.
module tb_switch_array_input;

  localparam int W = 8;
  localparam int D = 4;
  localparam int H = 8;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  logic [W-1:0] sw_in  [2];
  logic [W-1:0] lvl_o  [2];
  logic [W-1:0] rise_o [2];
  logic [W-1:0] fall_o [2];
  logic         rdy    [2];
  logic         ev_valid [2];
  logic [W-1:0] ev_data  [2];
  logic [W-1:0] ev_mask  [2];
  logic         ev_ovr   [2];

  switch_array_input_if #(.WIDTH(W)) ev0 ();
  switch_array_input_if #(.WIDTH(W)) ev1 ();

  assign ev0.event_ready = rdy[0];
  assign ev1.event_ready = rdy[1];
  assign ev_valid[0] = ev0.event_valid;  assign ev_valid[1] = ev1.event_valid;
  assign ev_data[0]  = ev0.event_data;   assign ev_data[1]  = ev1.event_data;
  assign ev_mask[0]  = ev0.event_mask;   assign ev_mask[1]  = ev1.event_mask;
  assign ev_ovr[0]   = ev0.event_overrun; assign ev_ovr[1]  = ev1.event_overrun;

  switch_array_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16), .ACTIVE_LOW(1'b0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .sw_in(sw_in[0]), .sw_level(lvl_o[0]),
    .sw_rise(rise_o[0]), .sw_fall(fall_o[0]), .ev(ev0.master));

  switch_array_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(16), .ACTIVE_LOW(1'b1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .sw_in(sw_in[1]), .sw_level(lvl_o[1]),
    .sw_rise(rise_o[1]), .sw_fall(fall_o[1]), .ev(ev1.master));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int i, input logic [W-1:0] act, input logic [W-1:0] e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h expected=%h @%0t", nm, i, act, e, $time);
    end
  endtask

  task automatic fail(input string nm, input int i);
    n_chk++;
    n_fail++;
    $display("FAIL %s[%0d] @%0t", nm, i, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int inst; logic [W-1:0] lvl; logic [W-1:0] rise; logic [W-1:0] fall; } pulse_t;
  typedef struct { int inst; logic [W-1:0] data; logic [W-1:0] mask; logic ovr; } xfer_t;
  pulse_t pulse_q[$];
  xfer_t  xfer_q[$];

  logic [W-1:0] m_lvl [2], m_rise [2], m_fall [2];
  logic         m_valid [2], m_ovr [2];
  logic [W-1:0] m_data [2], m_mask [2];
  logic [W-1:0] m_sh [2][H];   // m_sh[i][0] = pin seen at this edge (after inversion), older upward
  int           m_n [2];

  function automatic logic [W-1:0] eff(input int i, input logic [W-1:0] v);
    return (i == 1) ? ~v : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = '0; m_rise[i] = '0; m_fall[i] = '0;
      m_valid[i] = 1'b0; m_ovr[i] = 1'b0; m_data[i] = '0; m_mask[i] = '0;
      for (int k = 0; k < H; k++) m_sh[i][k] = eff(i, '0);  // sync flops hold raw 0
      m_n[i] = 2;
    end
    pulse_q.delete();
    xfer_q.delete();
  endtask

  task automatic model_edge(input int i);
    logic [W-1:0] chg;
    logic         acc;
    chg = m_rise[i] | m_fall[i];
    if (m_valid[i] && rdy[i]) xfer_q.push_back('{i, m_data[i], m_mask[i], m_ovr[i]});
    if (!m_valid[i]) begin
      if (chg != '0) begin m_valid[i] = 1'b1; m_data[i] = m_lvl[i]; m_mask[i] = chg; m_ovr[i] = 1'b0; end
    end else if (rdy[i]) begin
      if (chg != '0) begin m_data[i] = m_lvl[i]; m_mask[i] = chg; m_ovr[i] = 1'b0; end
      else begin m_valid[i] = 1'b0; m_mask[i] = '0; m_ovr[i] = 1'b0; end
    end else if (chg != '0) begin
      m_data[i] = m_lvl[i]; m_mask[i] = m_mask[i] | chg; m_ovr[i] = 1'b1;
    end
    // Pin value reaches the debounce logic two edges late; accept when the last D
    // values it saw all disagree with the current level.
    for (int k = H - 1; k > 0; k--) m_sh[i][k] = m_sh[i][k-1];
    m_sh[i][0] = eff(i, sw_in[i]);
    if (m_n[i] < H) m_n[i]++;
    m_rise[i] = '0; m_fall[i] = '0;
    for (int b = 0; b < W; b++) begin
      if (m_n[i] >= 2 + D) begin
        acc = 1'b1;
        for (int j = 0; j < D; j++) if (m_sh[i][2+j][b] == m_lvl[i][b]) acc = 1'b0;
        if (acc) begin
          m_lvl[i][b] = ~m_lvl[i][b];
          if (m_lvl[i][b]) m_rise[i][b] = 1'b1; else m_fall[i][b] = 1'b1;
        end
      end
    end
    if ((m_rise[i] | m_fall[i]) != '0) pulse_q.push_back('{i, m_lvl[i], m_rise[i], m_fall[i]});
  endtask

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) model_reset();
    else for (int i = 0; i < 2; i++) model_edge(i);
  end

  // ---------------- monitor ----------------
  logic         obs_hs [2];
  logic [W-1:0] obs_data [2], obs_mask [2];
  logic         obs_ovr [2];

  // Capture what the DUT presents ahead of the coming edge.
  always @(negedge CLK) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      obs_hs[i]   = ev_valid[i] && rdy[i];
      obs_data[i] = ev_data[i];
      obs_mask[i] = ev_mask[i];
      obs_ovr[i]  = ev_ovr[i];
    end
  end

  always @(posedge CLK) begin
    #1;
    if (RESET_N) begin
      for (int i = 0; i < 2; i++) begin
        pulse_t p;
        xfer_t  x;
        chk("level", i, lvl_o[i], m_lvl[i]);
        chk("valid", i, W'(ev_valid[i]), W'(m_valid[i]));
        if (m_valid[i]) begin
          chk("data", i, ev_data[i], m_data[i]);
          chk("mask", i, ev_mask[i], m_mask[i]);
          chk("overrun", i, W'(ev_ovr[i]), W'(m_ovr[i]));
        end
        if ((rise_o[i] | fall_o[i]) != '0) begin
          if (pulse_q.size() > 0 && pulse_q[0].inst == i) begin
            p = pulse_q.pop_front();
            chk("pulse_rise", i, rise_o[i], p.rise);
            chk("pulse_fall", i, fall_o[i], p.fall);
            chk("pulse_level", i, lvl_o[i], p.lvl);
          end else fail("unexpected_pulse", i);
        end
        if (obs_hs[i]) begin
          if (xfer_q.size() > 0 && xfer_q[0].inst == i) begin
            x = xfer_q.pop_front();
            chk("xfer_data", i, obs_data[i], x.data);
            chk("xfer_mask", i, obs_mask[i], x.mask);
            chk("xfer_ovr", i, W'(obs_ovr[i]), W'(x.ovr));
          end else fail("unexpected_transfer", i);
        end
      end
      if (pulse_q.size() > 0) begin fail("missing_pulse", pulse_q[0].inst); pulse_q.delete(); end
      if (xfer_q.size() > 0)  begin fail("missing_transfer", xfer_q[0].inst); xfer_q.delete(); end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drain();
    @(negedge CLK); rdy[0] = 1'b1; rdy[1] = 1'b1;
    @(negedge CLK); rdy[0] = 1'b0; rdy[1] = 1'b0;
  endtask

  initial begin
    sw_in[0] = 8'h00; sw_in[1] = 8'hFF; rdy[0] = 1'b0; rdy[1] = 1'b0;
    #1 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_level", 0, lvl_o[0], 8'h00);
    chk("rst_valid", 0, W'(ev_valid[0]), W'(1'b0));
    RESET_N = 1'b1; sw_in[0] = 8'h01;
    repeat (6) @(posedge CLK); #1;
    chk("tp_level", 0, lvl_o[0], 8'h01);
    chk("tp_rise", 0, rise_o[0], 8'h01);
    @(posedge CLK); #1;
    chk("tp_valid", 0, W'(ev_valid[0]), W'(1'b1));
    chk("tp_data", 0, ev_data[0], 8'h01);
    chk("tp_mask", 0, ev_mask[0], 8'h01);
    chk("tp_rise_gone", 0, rise_o[0], 8'h00);
    chk("al_idle_valid", 1, W'(ev_valid[1]), W'(1'b0));
    drain();

    // 3-clock glitch on bit 2; meanwhile press bit 0 on the active-low instance
    @(negedge CLK); sw_in[0][2] = 1'b1; sw_in[1][0] = 1'b0;
    repeat (3) @(negedge CLK); sw_in[0][2] = 1'b0;
    repeat (3) @(negedge CLK);
    chk("al_level", 1, lvl_o[1], 8'h01);
    chk("al_rise", 1, rise_o[1], 8'h01);
    repeat (3) @(negedge CLK);
    chk("glitch_level", 0, lvl_o[0], 8'h01);
    chk("glitch_valid", 0, W'(ev_valid[0]), W'(1'b0));
    // 4-clock pulse is accepted both ways
    sw_in[0][2] = 1'b1;
    repeat (4) @(negedge CLK); sw_in[0][2] = 1'b0;
    repeat (12) @(negedge CLK);
    drain();

    // two rises merged into one pending event
    @(negedge CLK); sw_in[0][3] = 1'b1;
    repeat (2) @(negedge CLK); sw_in[0][5] = 1'b1;
    repeat (10) @(negedge CLK);
    chk("ovr_mask", 0, ev_mask[0], 8'h28);
    chk("ovr_data", 0, ev_data[0], 8'h29);
    chk("ovr_flag", 0, W'(ev_ovr[0]), W'(1'b1));
    rdy[0] = 1'b1;
    @(negedge CLK); rdy[0] = 1'b0;
    chk("ovr_cleared", 0, W'(ev_valid[0]), W'(1'b0));

    // handshake on the same edge as a new change
    @(negedge CLK); sw_in[0][6] = 1'b1;
    repeat (3) @(negedge CLK); sw_in[0][7] = 1'b1;
    repeat (6) @(negedge CLK); rdy[0] = 1'b1;
    @(posedge CLK); #1;
    chk("same_valid", 0, W'(ev_valid[0]), W'(1'b1));
    chk("same_mask", 0, ev_mask[0], 8'h80);
    chk("same_ovr", 0, W'(ev_ovr[0]), W'(1'b0));
    @(negedge CLK); rdy[0] = 1'b0;
    drain();

    // async reset with an event pending and a count in flight
    @(negedge CLK); sw_in[0][1] = 1'b1;
    repeat (7) @(negedge CLK); sw_in[0][4] = 1'b1;
    repeat (2) @(negedge CLK); sw_in[0] = 8'hFF;
    #3 RESET_N = 1'b0;
    #1;
    chk("arst_level", 0, lvl_o[0], 8'h00);
    chk("arst_rise", 0, rise_o[0], 8'h00);
    chk("arst_valid", 0, W'(ev_valid[0]), W'(1'b0));
    chk("arst_data", 0, ev_data[0], 8'h00);
    chk("arst_mask", 0, ev_mask[0], 8'h00);
    chk("arst_ovr", 0, W'(ev_ovr[0]), W'(1'b0));
    repeat (2) @(negedge CLK); RESET_N = 1'b1;
    repeat (6) @(posedge CLK); #1;
    chk("held_level", 0, lvl_o[0], 8'hFF);
    @(posedge CLK); #1;
    chk("held_valid", 0, W'(ev_valid[0]), W'(1'b1));
    chk("held_mask", 0, ev_mask[0], 8'hFF);
    drain();

    // random phase
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) begin
          int k;
          k = int'($urandom_range(W - 1));
          sw_in[i][k] = ~sw_in[i][k];
        end
        rdy[i] = ($urandom_range(2) == 0);
      end
      if (n == 1500) begin
        #3 RESET_N = 1'b0;
        @(negedge CLK); RESET_N = 1'b1;
      end
    end
    repeat (10) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
